mul12_seq: RTL and testbench
============================

MUL12_SEQ -- requirements
Module: mul12_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: operands 12 bits, product 24 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low.
REQ-004 start_valid  input  1  requester presents operands a, b.
REQ-005 start_ready  output  1  block can accept operands.
REQ-006 a  input  12  unsigned multiplicand.
REQ-007 b  input  12  unsigned multiplier.
REQ-008 res_valid  output  1  res holds a completed product.
REQ-009 res_ready  input  1  consumer accepts res.
REQ-010 res  output  24  unsigned product a*b.
REQ-011 busy  output  1  high in every state other than IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, MUL, DONE.
REQ-013 In IDLE, start_ready SHALL be 1; in MUL and DONE, start_ready SHALL be 0.
REQ-014 An operation SHALL be accepted on the edge where start_valid=1 and start_ready=1. At that edge: a and b latch into internal registers, the 24-bit accumulator clears, step counter = 0, state -> MUL.
REQ-015 After acceptance, changes on a, b or start_valid SHALL NOT affect the operation in progress.
REQ-016 MUL SHALL last exactly 4 cycles, steps 0..3, using one shared 6x6 multiplier slice per step:
- step0: a[5:0]*b[5:0], shift 0
- step1: a[11:6]*b[5:0], shift 6
- step2: a[5:0]*b[11:6], shift 6
- step3: a[11:6]*b[11:6], shift 12
REQ-017 Each MUL edge SHALL add the shifted 12-bit slice product to the accumulator, modulo 2^24; no intermediate overflow is possible for unsigned operands.
REQ-018 On the step-3 edge, state SHALL go to DONE. res_valid therefore rises exactly 4 edges after the accept edge.
REQ-019 In DONE: res_valid=1, and res SHALL equal the accumulator, held stable until the handshake.
REQ-020 When res_valid=1 and res_ready=1 on an edge, state SHALL go to IDLE. res_ready low SHALL hold DONE indefinitely.
REQ-021 Outside DONE, res_valid SHALL be 0; res SHALL show the accumulator, and its value is don't-care there.
REQ-022 start_valid asserted in MUL or DONE SHALL be ignored and not queued; the requester holds it until start_ready=1.
REQ-023 Throughput: at most one product per 6 cycles (accept, 4xMUL, DONE handshake). Back-to-back acceptance occurs on the cycle after the DONE handshake.
REQ-024 Operand or product values 0 need no special-case timing; latency is always 4.

Reset
REQ-025 When rst_n=0 at an edge, the block SHALL set: state=IDLE, step=0, accumulator=0, operand registers=0.
REQ-026 Output values during reset SHALL be: start_ready=1, res_valid=0, busy=0, res=0.
REQ-027 Reset asserted in MUL or DONE SHALL discard the operation with no res_valid pulse. The first accept is possible on the first edge with rst_n=1.

Structure
REQ-028 Package mul12_pkg SHALL hold:
- the state enumeration (IDLE, MUL, DONE)
- OP_W=12, SLICE_W=6, PROD_W=24
- LAST_STEP=3
REQ-029 The slice multiplier SHALL be exactly one instance of the existing combinational wallace_tree_6 (6-bit op1/op2, 12-bit res). A slice-select multiplexer in mul12_seq drives it; no second multiplier instance is allowed.
REQ-030 The shift-and-add into the accumulator SHALL be plain RTL in mul12_seq; no further sub-modules.

Verification
REQ-031 a=0xFFF, b=0xFFF, res_ready=1 -> res_valid rises 4 edges after accept, res=0xFFE001, then IDLE.
REQ-032 a=0x800, b=0x002 -> res=0x001000. a=0x000, b=0xABC -> res=0x000000, same latency.
REQ-033 a=0x123, b=0x456 with res_ready held 0 for 10 cycles -> res_valid and res=0x04EDC2 stable throughout; IDLE on the edge after res_ready=1.
REQ-034 New start_valid with a=0x001, b=0x001 during MUL -> ignored, start_ready=0. The first result still matches its own operands. The second operation is accepted only from IDLE, and its res=0x000001.
REQ-035 rst_n=0 for one edge at MUL step 2 -> next cycle IDLE, res_valid=0, res=0, start_ready=1; no stale result ever appears.
REQ-036 10,000 random a, b with random res_ready stalls -> every res equals a*b, and latency is always 4 edges from accept to res_valid.

Source files
------------

// File: rtl/mul12_pkg.sv
// mul12_pkg: shared types and constants for the sequential 12x12 multiplier.
//   state_e   : FSM states (IDLE, MUL, DONE)
//   OP_W      : operand width
//   SLICE_W   : width of one multiplier slice operand
//   PROD_W    : product / accumulator width
//   LAST_STEP : index of the final MUL step
package mul12_pkg;

  localparam int OP_W    = 12;
  localparam int SLICE_W = 6;
  localparam int PROD_W  = 24;

  localparam logic [1:0] LAST_STEP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wallace_tree_6.sv
// wallace_tree_6: combinational 6x6 unsigned multiplier.
//   op1 [5:0]  : multiplicand
//   op2 [5:0]  : multiplier
//   res [11:0] : op1 * op2
// Six partial-product rows are reduced with 3:2 carry-save stages down to two
// rows, which a single carry-propagate adder then sums. The product always fits
// in 12 bits, so every row is carried at 12 bits and dropped carries are zero.
module wallace_tree_6 (
  input  logic [5:0]  op1,
  input  logic [5:0]  op2,
  output logic [11:0] res
);

  logic [11:0] pp [6];
  logic [11:0] s0, c0, s1, c1, s2, c2, s3, c3;

  // 3:2 compressor over whole rows: sum bits and left-shifted carry bits.
  function automatic logic [23:0] csa(input logic [11:0] x, input logic [11:0] y,
                                      input logic [11:0] z);
    logic [11:0] s;
    logic [11:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      pp[i] = ({6'b0, op1} & {12{op2[i]}}) << i;
    end
    {s0, c0} = csa(pp[0], pp[1], pp[2]);
    {s1, c1} = csa(pp[3], pp[4], pp[5]);
    {s2, c2} = csa(s0, c0, s1);
    {s3, c3} = csa(s2, c2, c1);
    res      = s3 + c3;
  end

endmodule

// File: rtl/mul12_seq.sv
// mul12_seq: sequential 12x12 unsigned multiplier built from one 6x6 slice.
//   clk, rst_n        : clock, synchronous active-low reset
//   start_valid/ready : operand handshake; a, b captured on the accept edge
//   a, b [11:0]       : unsigned operands
//   res_valid/ready   : result handshake; res held stable while res_valid=1
//   res [23:0]        : product (shows the accumulator outside DONE)
//   busy              : high whenever the FSM is not in IDLE
//
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1.
// The producer holds valid (and data) until that edge; ready never depends
// combinationally on valid. start_valid outside IDLE is ignored, not queued.
//
// Operation: IDLE --accept--> MUL (4 edges, steps 0..3) --> DONE --res_ready--> IDLE.
// Each MUL edge adds one shifted slice product of the latched operands.
module mul12_seq
  import mul12_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res,
  output logic              busy
);

  state_e              state_q;
  logic [1:0]          step_q;
  logic [OP_W-1:0]     a_q, b_q;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic                start_ready_q, res_valid_q, busy_q;

  logic [SLICE_W-1:0]  slice_op1, slice_op2;
  logic [2*SLICE_W-1:0] slice_res;
  logic [PROD_W-1:0]   addend;

  // Step bit 0 picks the high half of a, step bit 1 the high half of b:
  // step0 lo*lo, step1 hi*lo, step2 lo*hi, step3 hi*hi.
  always_comb begin
    slice_op1 = step_q[0] ? a_q[11:6] : a_q[5:0];
    slice_op2 = step_q[1] ? b_q[11:6] : b_q[5:0];
  end

  wallace_tree_6 u_slice (
    .op1 (slice_op1),
    .op2 (slice_op2),
    .res (slice_res)
  );

  // Weight of the slice product: 0, 6, 6, 12 bits for steps 0..3.
  always_comb begin
    addend = '0;
    case (step_q)
      2'd0:    addend = {12'b0, slice_res};
      2'd1,
      2'd2:    addend = {6'b0, slice_res, 6'b0};
      default: addend = {slice_res, 12'b0};
    endcase
    acc_d = acc_q + addend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      step_q        <= 2'd0;
      acc_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q           <= a;
            b_q           <= b;
            acc_q         <= '0;
            step_q        <= 2'd0;
            state_q       <= MUL;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        MUL: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == LAST_STEP) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          start_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign res         = acc_q;

endmodule

// File: tb/tb_mul12_seq.sv
// tb_mul12_seq: directed and randomized bench for mul12_seq.
// Expected products come from plain a*b arithmetic pushed into exp_q.
module tb_mul12_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] a, b;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res;
  logic        busy;

  int checks;
  int errors;
  logic [23:0] exp_q[$];

  mul12_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res         (res),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, expv);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  // stall   : cycles res_ready is held low once res_valid is up
  // intrude : drive start_valid with a=b=1 during MUL (must be ignored)
  task automatic run_op(input logic [11:0] x, input logic [11:0] y,
                        input int stall, input bit intrude);
    logic [23:0] expv;
    int lat;
    @(negedge clk);
    check("idle_ready", {23'b0, start_ready}, 24'd1);
    start_valid = 1'b1;
    a = x;
    b = y;
    res_ready = (stall == 0);
    exp_q.push_back(24'(x) * 24'(y));
    @(posedge clk);  // accept edge
    #1;
    if (intrude) begin
      start_valid = 1'b1;
      a = 12'h001;
      b = 12'h001;
    end else begin
      start_valid = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      b = 12'($urandom);
    end
    lat = 0;
    do begin
      check("mul_start_ready", {23'b0, start_ready}, 24'd0);
      check("mul_busy", {23'b0, busy}, 24'd1);
      @(posedge clk);
      #1;
      lat++;
    end while (!res_valid && lat < 20);
    start_valid = 1'b0;
    check("latency", 24'(lat), 24'd4);
    expv = exp_q.pop_front();
    check("res", res, expv);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {23'b0, res_valid}, 24'd1);
      check("stall_res", res, expv);
    end
    res_ready = 1'b1;
    @(posedge clk);  // handshake edge
    #1;
    res_ready = 1'b0;
    check("post_valid", {23'b0, res_valid}, 24'd0);
    check("post_ready", {23'b0, start_ready}, 24'd1);
    check("post_busy", {23'b0, busy}, 24'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    res_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {23'b0, start_ready}, 24'd1);
    check("rst_valid", {23'b0, res_valid}, 24'd0);
    check("rst_busy", {23'b0, busy}, 24'd0);
    check("rst_res", res, 24'd0);
    rst_n = 1'b1;

    // Directed corner operands
    run_op(12'hFFF, 12'hFFF, 0, 1'b0);
    run_op(12'h800, 12'h002, 0, 1'b0);
    run_op(12'h000, 12'hABC, 0, 1'b0);
    run_op(12'h123, 12'h456, 10, 1'b0);
    run_op(12'h5A5, 12'hC3C, 2, 1'b1);
    run_op(12'h001, 12'h001, 0, 1'b0);

    // Reset during MUL step 2 discards the operation
    @(negedge clk);
    start_valid = 1'b1;
    a = 12'hABC;
    b = 12'hDEF;
    res_ready = 1'b1;
    @(posedge clk);  // accept -> step 0
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);  // step 2
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_ready", {23'b0, start_ready}, 24'd1);
    check("midrst_valid", {23'b0, res_valid}, 24'd0);
    check("midrst_busy", {23'b0, busy}, 24'd0);
    check("midrst_res", res, 24'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_stale", {23'b0, res_valid}, 24'd0);
    end
    res_ready = 1'b0;
    run_op(12'h3C5, 12'h0F7, 0, 1'b0);

    // Randomized operands with occasional consumer stalls
    for (int n = 0; n < 10000; n++) begin
      int st;
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(12'($urandom), 12'($urandom), st, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
